coil_sequencer: RTL
===================

# coil_sequencer

Parametrised multi-stage coil launcher controller, the successor to the single-coil launch block. A synchronised trigger edge charges the capacitor bank for a fixed time, fires N coils in order with programmable pulse and gap lengths, then enforces a cooldown before the next shot. It also drives the servo PWM, with duty selected by sequencer state. It sits between the pushbutton inputs and the coil driver and servo pins.

## Interface
- N_COILS, 3: number of coil stages (1..8)
- CW, 32: width of the phase counter
- CHARGE_CYCLES, 100000000: capacitor charge time in clk cycles (>=1)
- FIRE_CYCLES, 50000: per-coil fire pulse length (>=1)
- GAP_CYCLES, 20000: dead time between successive coils (>=1)
- COOLDOWN_CYCLES, 50000000: lockout after a shot (>=1)
- PWM_PERIOD, 588000: servo PWM period in cycles
- DUTY_IDLE, 20000: servo high time in IDLE/COOLDOWN
- DUTY_ARMED, 10000: servo high time in CHARGE/FIRE/GAP

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- trig  in  1  raw pushbutton; asynchronous to clk
- abort  in  1  synchronous level; ends any active shot
- charge_n  out  1  capacitor charge enable, active low
- fire  out  N_COILS  one-hot coil fire enables
- pwm_out  out  1  servo PWM
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a completed shot returns to IDLE
- aborted  out  1  sticky; set by abort, cleared by the next accepted trigger
- coil_idx  out  3  index of the current or next coil

## Operation
- trig passes through a 2-FF synchroniser. A rising-edge detector compares the second stage with a delayed copy.
- FSM states: IDLE, CHARGE, FIRE, GAP, COOLDOWN. The phase counter clears on every state entry.
- IDLE -> CHARGE on a synchronised rising edge. Edges seen in any other state are dropped and are not queued. Entering CHARGE clears `aborted` and sets `coil_idx`=0.
- CHARGE -> FIRE after CHARGE_CYCLES cycles.
- FIRE -> GAP after FIRE_CYCLES cycles, if `coil_idx` < N_COILS-1.
- FIRE -> COOLDOWN after FIRE_CYCLES cycles, if `coil_idx` = N_COILS-1.
- GAP -> FIRE after GAP_CYCLES cycles, with `coil_idx` incremented on entry to FIRE.
- COOLDOWN -> IDLE after COOLDOWN_CYCLES cycles. `done` pulses on this transition only if `aborted`=0.
- abort high in CHARGE, FIRE or GAP forces COOLDOWN on the next edge and sets `aborted`. abort is ignored in IDLE and COOLDOWN. A full COOLDOWN is always served.
- Output decode from the state register:
  - charge_n=0 only in CHARGE.
  - fire[coil_idx]=1 only in FIRE.
  - charge_n and fire are never active together.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1, wrapping to 0.
  - pwm_out = (counter < active_duty).
  - active_duty loads the state-selected duty only when the counter wraps to 0, so no partial pulses occur.
- Counter arithmetic is unsigned CW-bit. Every parameter must fit in CW bits; elaboration fails otherwise.

## Timing
- Reset values: state=IDLE, charge_n=1, fire=0, busy=0, done=0, aborted=0, coil_idx=0, PWM counter=0, active_duty=DUTY_IDLE, synchroniser and edge registers=0.
- Reset mid-shot drops charge_n and fire to inactive immediately (asynchronously).
- Trigger latency: trig high sampled at edge t0 gives charge_n low after edge t0+2.
- CHARGE lasts exactly CHARGE_CYCLES cycles, each FIRE exactly FIRE_CYCLES, each GAP exactly GAP_CYCLES, and COOLDOWN exactly COOLDOWN_CYCLES.
- Full shot length: CHARGE_CYCLES + N·FIRE_CYCLES + (N-1)·GAP_CYCLES + COOLDOWN_CYCLES.
- Abort latency: abort high at edge t forces outputs inactive after edge t. COOLDOWN starts at t.
- A trig edge arriving in the same cycle as COOLDOWN -> IDLE is dropped. The next edge starts a shot.
- PWM duty change takes effect at the first wrap after the state change, at most PWM_PERIOD cycles later.

## Test plan
- Nominal shot: N_COILS=3, CHARGE=10, FIRE=4, GAP=2, COOLDOWN=8, pulse trig -> charge_n low 10 cycles, then fire=001,010,100 each 4 cycles separated by 2 idle cycles, busy high 34 cycles, done pulses once.
- Abort in second FIRE (2 cycles in) -> fire=0 next cycle, COOLDOWN 8 cycles, aborted=1, no done. The next trig clears aborted.
- Retrigger lockout: 5 trig pulses during CHARGE and COOLDOWN -> exactly one shot. A trig one cycle after done starts a new shot.
- Async reset asserted mid-CHARGE off-clock-edge -> charge_n=1 without waiting for a clock edge. State IDLE after release.
- PWM: PWM_PERIOD=100, DUTY_IDLE=20, DUTY_ARMED=10 -> 20-high/80-low idle, switching to 10-high only at the wrap after CHARGE entry, with no runt pulse.
- Edge case N_COILS=1: fire=1 for FIRE cycles and no GAP state is visited.

Source files
------------

// File: rtl/coil_sequencer.sv
// coil_sequencer: multi-stage coil launcher controller.
// Charge, N fire/gap pulses, cooldown lockout, plus state-selected servo PWM.
module coil_sequencer #(
    parameter int unsigned N_COILS         = 3,
    parameter int unsigned CW              = 32,
    parameter int unsigned CHARGE_CYCLES   = 100000000,
    parameter int unsigned FIRE_CYCLES     = 50000,
    parameter int unsigned GAP_CYCLES      = 20000,
    parameter int unsigned COOLDOWN_CYCLES = 50000000,
    parameter int unsigned PWM_PERIOD      = 588000,
    parameter int unsigned DUTY_IDLE       = 20000,
    parameter int unsigned DUTY_ARMED      = 10000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig,
    input  logic               abort,
    output logic               charge_n,
    output logic [N_COILS-1:0] fire,
    output logic               pwm_out,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [2:0]         coil_idx
);

    function automatic bit fits(input longint unsigned v);
        return (v >> CW) == 64'd0;
    endfunction

    if (N_COILS == 0 || N_COILS > 8 || CW == 0 ||
        CHARGE_CYCLES == 0 || FIRE_CYCLES == 0 ||
        GAP_CYCLES == 0 || COOLDOWN_CYCLES == 0 ||
        PWM_PERIOD == 0 ||
        !fits(64'(CHARGE_CYCLES)) || !fits(64'(FIRE_CYCLES)) ||
        !fits(64'(GAP_CYCLES)) || !fits(64'(COOLDOWN_CYCLES)) ||
        !fits(64'(PWM_PERIOD)) || !fits(64'(DUTY_IDLE)) ||
        !fits(64'(DUTY_ARMED))) begin : g_bad_param
        $error("coil_sequencer: illegal parameter set");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_FIRE   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_COOL   = 3'd4;

    localparam logic [CW-1:0] CHG_LAST  = CW'(CHARGE_CYCLES - 1);
    localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] D_IDLE    = CW'(DUTY_IDLE);
    localparam logic [CW-1:0] D_ARMED   = CW'(DUTY_ARMED);
    localparam logic [2:0]    LAST_COIL = 3'(N_COILS - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] phase_last;
    logic [CW-1:0] pwm_cnt;
    logic [CW-1:0] active_duty;
    logic [CW-1:0] sel_duty;
    logic          trig_s1;
    logic          trig_s2;
    logic          trig_d;
    logic          rise;
    logic          phase_end;
    logic          armed;

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign rise = trig_s2 & ~trig_d;

    // Terminal count of the phase counter for the current state
    always_comb begin
        phase_last = '0;
        unique case (1'b1)
            state == S_CHARGE: phase_last = CHG_LAST;
            state == S_FIRE:   phase_last = FIRE_LAST;
            state == S_GAP:    phase_last = GAP_LAST;
            state == S_COOL:   phase_last = COOL_LAST;
            default:           phase_last = '0;
        endcase
    end

    assign phase_end = (cnt == phase_last);
    assign armed = (state == S_CHARGE) || (state == S_FIRE) ||
                   (state == S_GAP);

    // Shot sequencer; abort wins over any phase transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            coil_idx <= '0;
            aborted  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (armed && abort) begin
                state   <= S_COOL;
                cnt     <= '0;
                aborted <= 1'b1;
            end else if (state != S_IDLE && !phase_end) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
                unique case (state)
                    S_IDLE: begin
                        if (rise) begin
                            state    <= S_CHARGE;
                            coil_idx <= '0;
                            aborted  <= 1'b0;
                        end
                    end
                    S_CHARGE: state <= S_FIRE;
                    S_FIRE: begin
                        if (coil_idx == LAST_COIL) state <= S_COOL;
                        else                       state <= S_GAP;
                    end
                    S_GAP: begin
                        state    <= S_FIRE;
                        coil_idx <= coil_idx + 3'd1;
                    end
                    S_COOL: begin
                        state <= S_IDLE;
                        done  <= !aborted;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign charge_n = (state != S_CHARGE);
    assign fire     = (state == S_FIRE) ? (N_COILS'(1) << coil_idx) : '0;
    assign sel_duty = (state == S_IDLE || state == S_COOL) ? D_IDLE : D_ARMED;

    // Free-running PWM; duty only reloads at wrap so pulses are never cut short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            active_duty <= D_IDLE;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt     <= '0;
            active_duty <= sel_duty;
        end else begin
            pwm_cnt <= pwm_cnt + CW'(1);
        end
    end

    assign pwm_out = (pwm_cnt < active_duty);

endmodule
